// File: rtl/arb_merge_pkg.sv
// Shared constants and helpers for the N-to-1 arbitrated merge.
package arb_merge_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
    localparam int MAX_CH    = 64;

    // Binary index of the set bit in a one-hot vector; all-zero maps to 0.
    function automatic int onehot2bin(input logic [MAX_CH-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// N-way arbiter: fixed priority (lowest index) or round-robin from a rotating pointer.
module rr_arbiter_n
    import arb_merge_pkg::*;
#(
    parameter  int NUM_CH   = 5,
    parameter  int ARB_MODE = ARB_FIXED,
    localparam int ID_W     = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] req,
    input  logic              load,
    output logic [NUM_CH-1:0] grant,
    output logic [ID_W-1:0]   grant_idx
);

    logic [ID_W-1:0]   ptr;
    logic [NUM_CH-1:0] masked;
    logic [NUM_CH-1:0] pick;

    // Requests at or above ptr take precedence; if none, fall back to the full
    // request set, which gives the modulo-NUM_CH wrap. Fixed mode never masks.
    always_comb begin
        masked = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            masked[i] = req[i] && (ARB_MODE == ARB_RR) && (i >= int'(ptr));
        end
        pick  = (|masked) ? masked : req;
        grant = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pick[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

    assign grant_idx = ID_W'(onehot2bin(MAX_CH'(grant)));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (load && (ARB_MODE == ARB_RR)) begin
            ptr <= (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/arb_merge_n.sv
// N-to-1 arbitrated merge: one holding register per channel feeding a single
// output register, with source-ID tagging and one word per cycle throughput.
module arb_merge_n
    import arb_merge_pkg::*;
#(
    parameter  int NUM_CH     = 5,
    parameter  int DATA_WIDTH = 12,
    parameter  int ARB_MODE   = ARB_FIXED,
    localparam int ID_W       = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_CH-1:0]            i_drive_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_data_n,
    output logic [NUM_CH-1:0]            o_free_n,
    output logic                         o_driveNext,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [ID_W-1:0]              o_id,
    input  logic                         i_freeNext
);

    // Handshakes are valid/ready: a word moves on a rising edge where valid
    // and ready are both 1. o_free_n comes straight from the holder flags, so
    // ready never depends combinationally on any valid or downstream ready.

    logic [NUM_CH-1:0]     full;
    logic [DATA_WIDTH-1:0] hold [NUM_CH];
    logic [NUM_CH-1:0]     grant;
    logic [ID_W-1:0]       grant_idx;
    logic                  load;
    logic [DATA_WIDTH-1:0] win_data;

    assign o_free_n = ~full;
    assign load     = (|full) && (!o_driveNext || i_freeNext);

    rr_arbiter_n #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .req       (full),
        .load      (load),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                win_data = win_data | hold[i];
            end
        end
    end

    // Grant only hits full holders and capture only hits empty ones, so the
    // two never collide on the same holder.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            full <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (load && grant[i]) begin
                    full[i] <= 1'b0;
                end else if (i_drive_n[i] && !full[i]) begin
                    full[i] <= 1'b1;
                    hold[i] <= i_data_n[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_driveNext <= 1'b0;
            o_data      <= '0;
            o_id        <= '0;
        end else if (load) begin
            o_driveNext <= 1'b1;
            o_data      <= win_data;
            o_id        <= grant_idx;
        end else if (i_freeNext) begin
            o_driveNext <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_merge_n.sv
// Self-checking bench for arb_merge_n: fixed-priority and round-robin instances
// share stimulus and are checked against a cycle model plus a data scoreboard.
module tb_arb_merge_n;

    localparam int NUM_CH = 5;
    localparam int DW     = 12;
    localparam int ID_W   = 3;
    localparam int SBW    = 1 + ID_W + DW;

    logic                   clk       = 1'b0;
    logic                   rstn      = 1'b0;
    logic [NUM_CH-1:0]      drive     = '0;
    logic [NUM_CH*DW-1:0]   data_in   = '0;
    logic                   free_next = 1'b0;

    logic [NUM_CH-1:0] free_o [2];
    logic              drv_o  [2];
    logic [DW-1:0]     dat_o  [2];
    logic [ID_W-1:0]   id_o   [2];

    int total = 0;
    int bad   = 0;
    int pops [2];

    logic [SBW-1:0] exp_q[$];

    arb_merge_n #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .ARB_MODE(0)) u_fix (
        .clk(clk), .rstn(rstn), .i_drive_n(drive), .i_data_n(data_in),
        .o_free_n(free_o[0]), .o_driveNext(drv_o[0]), .o_data(dat_o[0]),
        .o_id(id_o[0]), .i_freeNext(free_next)
    );

    arb_merge_n #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .ARB_MODE(1)) u_rr (
        .clk(clk), .rstn(rstn), .i_drive_n(drive), .i_data_n(data_in),
        .o_free_n(free_o[1]), .o_driveNext(drv_o[1]), .o_data(dat_o[1]),
        .o_id(id_o[1]), .i_freeNext(free_next)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Abstract view: per-channel full flags and payloads, one output slot,
    // and an integer search start for round-robin (index 1).
    bit            m_full [2][NUM_CH];
    logic [DW-1:0] m_hold [2][NUM_CH];
    bit            m_vld  [2];
    logic [DW-1:0] m_dat  [2];
    int            m_id   [2];
    int            m_ptr  [2];
    int            mdl_w, mdl_start, mdl_c;
    bit            mdl_ld;

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!rstn) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    m_full[m][c] = 1'b0;
                    m_hold[m][c] = '0;
                end
                m_vld[m] = 1'b0;
                m_dat[m] = '0;
                m_id[m]  = 0;
                m_ptr[m] = 0;
            end else begin
                mdl_w     = -1;
                mdl_start = (m == 1) ? m_ptr[m] : 0;
                for (int k = 0; k < NUM_CH; k++) begin
                    mdl_c = (mdl_start + k) % NUM_CH;
                    if (mdl_w < 0 && m_full[m][mdl_c]) mdl_w = mdl_c;
                end
                mdl_ld = (mdl_w >= 0) && (!m_vld[m] || free_next);
                for (int c = 0; c < NUM_CH; c++) begin
                    if (!m_full[m][c] && drive[c]) begin
                        m_full[m][c] = 1'b1;
                        m_hold[m][c] = data_in[c*DW +: DW];
                    end
                end
                if (mdl_ld) begin
                    m_dat[m]         = m_hold[m][mdl_w];
                    m_id[m]          = mdl_w;
                    m_vld[m]         = 1'b1;
                    m_full[m][mdl_w] = 1'b0;
                    if (m == 1) m_ptr[m] = (mdl_w + 1) % NUM_CH;
                end else if (free_next) begin
                    m_vld[m] = 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    // Sampled mid-cycle: these are exactly the values the next edge will use.
    always @(negedge clk) begin
        int  idx;
        logic [SBW-1:0] w;
        for (int m = 0; m < 2; m++) begin
            if (!rstn) begin
                exp_q.delete();
            end else begin
                if (drv_o[m] && free_next) begin
                    w   = {1'(m), id_o[m], dat_o[m]};
                    idx = -1;
                    for (int j = 0; j < exp_q.size(); j++) begin
                        if (idx < 0 && exp_q[j] == w) idx = j;
                    end
                    total++;
                    pops[m]++;
                    if (idx < 0) begin
                        bad++;
                        $display("FAIL sb_unexpected mode=%0d got id=%0d data=%0h, required a previously accepted word",
                                 m, id_o[m], dat_o[m]);
                    end else begin
                        exp_q.delete(idx);
                    end
                end
                for (int c = 0; c < NUM_CH; c++) begin
                    if (drive[c] && free_o[m][c]) exp_q.push_back({1'(m), ID_W'(c), data_in[c*DW +: DW]});
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic model_check();
        logic [NUM_CH-1:0] ef;
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < NUM_CH; c++) ef[c] = !m_full[m][c];
            check($sformatf("mdl_free_m%0d", m), 32'(free_o[m]), 32'(ef));
            check($sformatf("mdl_drv_m%0d", m),  32'(drv_o[m]),  32'(m_vld[m]));
            check($sformatf("mdl_data_m%0d", m), 32'(dat_o[m]),  32'(m_dat[m]));
            check($sformatf("mdl_id_m%0d", m),   32'(id_o[m]),   32'(m_id[m]));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic rand_data();
        for (int c = 0; c < NUM_CH; c++) data_in[c*DW +: DW] = DW'($urandom);
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive     = NUM_CH'($urandom);
            free_next = 1'($urandom_range(0, 1));
            rand_data();
            tick();
        end
        for (int m = 0; m < 2; m++) begin
            check("rst_free", 32'(free_o[m]), 32'h1f);
            check("rst_drv",  32'(drv_o[m]),  32'h0);
            check("rst_data", 32'(dat_o[m]),  32'h0);
            check("rst_id",   32'(id_o[m]),   32'h0);
        end
        rstn      = 1'b1;
        drive     = '0;
        free_next = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [NUM_CH-1:0] drv;
        logic [DW-1:0]     d2;
        logic              fn;
        logic [NUM_CH-1:0] e_free;
        logic              e_drv;
        logic [DW-1:0]     e_data;
        logic [ID_W-1:0]   e_id;
    } vec_t;

    vec_t vt [7];
    int   n_out;

    initial begin
        pops[0] = 0;
        pops[1] = 0;
        vt[0] = '{5'b00100, 12'hABC, 1'b1, 5'b11011, 1'b0, 12'h000, 3'd0};
        vt[1] = '{5'b00000, 12'h000, 1'b1, 5'b11111, 1'b1, 12'hABC, 3'd2};
        vt[2] = '{5'b00000, 12'h000, 1'b1, 5'b11111, 1'b0, 12'hABC, 3'd2};
        vt[3] = '{5'b00100, 12'h5A5, 1'b0, 5'b11011, 1'b0, 12'hABC, 3'd2};
        vt[4] = '{5'b00000, 12'h000, 1'b0, 5'b11111, 1'b1, 12'h5A5, 3'd2};
        vt[5] = '{5'b00000, 12'h000, 1'b0, 5'b11111, 1'b1, 12'h5A5, 3'd2};
        vt[6] = '{5'b00000, 12'h000, 1'b1, 5'b11111, 1'b0, 12'h5A5, 3'd2};

        // Reset and single-word latency / stall table
        apply_reset();
        for (int v = 0; v < 7; v++) begin
            rand_data();
            drive            = vt[v].drv;
            data_in[2*DW +: DW] = vt[v].d2;
            free_next        = vt[v].fn;
            tick();
            for (int m = 0; m < 2; m++) begin
                check($sformatf("vec%0d_free", v), 32'(free_o[m]), 32'(vt[v].e_free));
                check($sformatf("vec%0d_drv", v),  32'(drv_o[m]),  32'(vt[v].e_drv));
                check($sformatf("vec%0d_data", v), 32'(dat_o[m]),  32'(vt[v].e_data));
                check($sformatf("vec%0d_id", v),   32'(id_o[m]),   32'(vt[v].e_id));
            end
        end

        // Fixed priority: channels 0, 3, 4 loaded together
        apply_reset();
        free_next = 1'b1;
        drive     = 5'b11001;
        for (int c = 0; c < NUM_CH; c++) data_in[c*DW +: DW] = DW'(12'h300 + c);
        tick();
        drive = '0;
        tick();
        check("fp_drv0", 32'(drv_o[0]), 32'h1);
        check("fp_id0",  32'(id_o[0]),  32'd0);
        check("fp_dat0", 32'(dat_o[0]), 32'h300);
        tick();
        check("fp_id1",  32'(id_o[0]),  32'd3);
        check("fp_dat1", 32'(dat_o[0]), 32'h303);
        tick();
        check("fp_id2",  32'(id_o[0]),  32'd4);
        check("fp_dat2", 32'(dat_o[0]), 32'h304);
        tick();
        check("fp_idle", 32'(drv_o[0]), 32'h0);

        // Round-robin: all channels driven continuously
        apply_reset();
        free_next = 1'b1;
        drive     = '1;
        n_out     = 0;
        for (int t = 0; t < 100 && n_out < 20; t++) begin
            rand_data();
            tick();
            if (drv_o[1]) begin
                check($sformatf("rr_seq%0d", n_out), 32'(id_o[1]), 32'(n_out % NUM_CH));
                n_out++;
            end
        end
        check("rr_count", 32'(n_out), 32'd20);

        // Backpressure: six words stuck behind a stalled output
        apply_reset();
        free_next = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive = '1;
            for (int c = 0; c < NUM_CH; c++) data_in[c*DW +: DW] = DW'(((k + 1) << 8) | c);
            tick();
        end
        drive = '0;
        for (int t = 0; t < 10; t++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                check("bp_drv",  32'(drv_o[m]),  32'h1);
                check("bp_data", 32'(dat_o[m]),  32'h100);
                check("bp_id",   32'(id_o[m]),   32'd0);
                check("bp_free", 32'(free_o[m]), 32'h0);
            end
        end
        free_next = 1'b1;
        pops[0]   = 0;
        pops[1]   = 0;
        for (int t = 0; t < 15; t++) tick();
        check("bp_words_fix", 32'(pops[0]), 32'd6);
        check("bp_words_rr",  32'(pops[1]), 32'd6);
        check("bp_sb_empty",  32'(exp_q.size()), 32'd0);

        // Reset mid-stream with three holders full and output valid
        apply_reset();
        drive = 5'b11110;
        for (int c = 0; c < NUM_CH; c++) data_in[c*DW +: DW] = DW'(12'h600 + c);
        tick();
        drive = '0;
        tick();
        check("mr_drv_pre",  32'(drv_o[0]),  32'h1);
        check("mr_free_pre", 32'(free_o[0]), 32'h03);
        rstn = 1'b0;
        tick();
        for (int m = 0; m < 2; m++) begin
            check("mr_free", 32'(free_o[m]), 32'h1f);
            check("mr_drv",  32'(drv_o[m]),  32'h0);
            check("mr_data", 32'(dat_o[m]),  32'h0);
            check("mr_id",   32'(id_o[m]),   32'h0);
        end
        rstn      = 1'b1;
        free_next = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick();
            check("mr_no_stale_fix", 32'(drv_o[0]), 32'h0);
            check("mr_no_stale_rr",  32'(drv_o[1]), 32'h0);
        end

        // Random traffic with occasional resets
        apply_reset();
        for (int t = 0; t < 1500; t++) begin
            drive     = NUM_CH'($urandom);
            free_next = ($urandom_range(0, 3) != 0);
            rstn      = ($urandom_range(0, 299) != 0);
            rand_data();
            tick();
        end
        rstn      = 1'b1;
        drive     = '0;
        free_next = 1'b1;
        for (int t = 0; t < 20; t++) tick();
        check("rand_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
